// File: rtl/voice_mix_sequencer.sv
// rtl/voice_mix_sequencer.sv - shares one fixed-point multiplier across voices and mixes the products
module voice_mix_sequencer #(
    parameter int C_WIDTH    = 32,
    parameter int NUM_VOICES = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic                          ctl_clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic [NUM_VOICES*C_WIDTH-1:0] samples,
    input  logic [NUM_VOICES*C_WIDTH-1:0] gains,
    input  logic [NUM_VOICES-1:0]         voice_en,
    output logic [C_WIDTH-1:0]            mul_a,
    output logic [C_WIDTH-1:0]            mul_b,
    output logic                          mul_trigger,
    input  logic                          mul_ready,
    input  logic                          mul_done,
    input  logic [C_WIDTH-1:0]            mul_y,
    output logic [C_WIDTH-1:0]            mix_out,
    output logic                          mix_valid,
    output logic                          busy,
    output logic                          overrun,
    output logic                          mul_error
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int AW = C_WIDTH + $clog2(NUM_VOICES) + 1;
    localparam int TW = 16;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_e;

    state_e                          state_q, state_d;
    logic [NUM_VOICES*C_WIDTH-1:0]   samp_q, samp_d;
    logic [NUM_VOICES*C_WIDTH-1:0]   gain_q, gain_d;
    logic [NUM_VOICES-1:0]           en_q, en_d;
    logic [AW-1:0]                   acc_q, acc_d;
    logic [VW-1:0]                   vidx_q, vidx_d;
    logic [TW-1:0]                   timer_q, timer_d;
    logic [C_WIDTH-1:0]              mix_q, mix_d;
    logic                            mix_valid_q, mix_valid_d;
    logic                            overrun_q, overrun_d;
    logic                            mul_error_q, mul_error_d;

    logic                            last_voice;
    logic [C_WIDTH-1:0]              cur_sample;
    logic [C_WIDTH-1:0]              cur_gain;

    assign last_voice = (vidx_q == VW'(NUM_VOICES - 1));
    assign cur_sample = samp_q[int'(vidx_q)*C_WIDTH +: C_WIDTH];
    assign cur_gain   = gain_q[int'(vidx_q)*C_WIDTH +: C_WIDTH];

    // Operands come straight from the latched frame so they stay stable across WAIT.
    assign mul_a     = (state_q == S_ISSUE || state_q == S_WAIT) ? cur_sample : '0;
    assign mul_b     = (state_q == S_ISSUE || state_q == S_WAIT) ? cur_gain : '0;
    assign mix_out   = mix_q;
    assign mix_valid = mix_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;
    assign mul_error = mul_error_q;

    always_comb begin
        state_d     = state_q;
        samp_d      = samp_q;
        gain_d      = gain_q;
        en_d        = en_q;
        acc_d       = acc_q;
        vidx_d      = vidx_q;
        timer_d     = timer_q;
        mix_d       = mix_q;
        mix_valid_d = 1'b0;
        overrun_d   = 1'b0;
        mul_error_d = 1'b0;
        mul_trigger = 1'b0;

        if (state_q != S_IDLE && frame_start) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    samp_d  = samples;
                    gain_d  = gains;
                    en_d    = voice_en;
                    acc_d   = '0;
                    vidx_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!en_q[vidx_q]) begin
                    if (last_voice) begin
                        state_d = S_OUT;
                    end else begin
                        vidx_d = vidx_q + VW'(1);
                    end
                end else if (mul_ready) begin
                    mul_trigger = 1'b1;
                    timer_d     = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mul_done) begin
                    acc_d = acc_q + AW'(mul_y);
                    if (last_voice) begin
                        state_d = S_OUT;
                    end else begin
                        vidx_d  = vidx_q + VW'(1);
                        state_d = S_ISSUE;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    mul_error_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_OUT: begin
                // Any bit above the output width means the sum exceeded full scale.
                mix_d       = (|acc_q[AW-1:C_WIDTH]) ? {C_WIDTH{1'b1}} : acc_q[C_WIDTH-1:0];
                mix_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ctl_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            samp_q      <= '0;
            gain_q      <= '0;
            en_q        <= '0;
            acc_q       <= '0;
            vidx_q      <= '0;
            timer_q     <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            mul_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            gain_q      <= gain_d;
            en_q        <= en_d;
            acc_q       <= acc_d;
            vidx_q      <= vidx_d;
            timer_q     <= timer_d;
            mix_q       <= mix_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
            mul_error_q <= mul_error_d;
        end
    end

endmodule

// File: tb/tb_voice_mix_sequencer.sv
// tb/tb_voice_mix_sequencer.sv - bench for voice_mix_sequencer with a behavioural multiplier and mix model
module tb_voice_mix_sequencer;

    localparam int CW = 32;
    localparam int NV = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             frame_start = 1'b0;
    logic [NV*CW-1:0] samples = '0;
    logic [NV*CW-1:0] gains = '0;
    logic [NV-1:0]    voice_en = '0;
    logic [CW-1:0]    mul_a, mul_b, mul_y, mix_out;
    logic             mul_trigger, mul_ready, mul_done;
    logic             mix_valid, busy, overrun, mul_error;

    int   n_cmp = 0;
    int   n_err = 0;
    int   m_lat = 1;
    logic dead = 1'b0;
    logic rand_ready = 1'b0;
    logic stray_req = 1'b0;

    logic          pend;
    int            cnt;
    logic [CW-1:0] res_q;

    voice_mix_sequencer #(.C_WIDTH(CW), .NUM_VOICES(NV), .TIMEOUT(TO)) dut (
        .ctl_clk(clk), .reset(reset), .frame_start(frame_start),
        .samples(samples), .gains(gains), .voice_en(voice_en),
        .mul_a(mul_a), .mul_b(mul_b), .mul_trigger(mul_trigger),
        .mul_ready(mul_ready), .mul_done(mul_done), .mul_y(mul_y),
        .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy),
        .overrun(overrun), .mul_error(mul_error)
    );

    always #5 clk = ~clk;

    // Q8 fixed-point product, saturated to the sample width
    function automatic logic [CW-1:0] fx(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [63:0] p;
        p = (64'(a) * 64'(b)) >> 8;
        return (p[63:32] != 0) ? {CW{1'b1}} : p[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] mix_ref(input logic [NV*CW-1:0] s, input logic [NV*CW-1:0] g,
                                              input logic [NV-1:0] e);
        logic [63:0] acc;
        acc = 0;
        for (int v = 0; v < NV; v++)
            if (e[v]) acc += 64'(fx(s[v*CW +: CW], g[v*CW +: CW]));
        return (acc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : acc[31:0];
    endfunction

    // Multiplier: accepts on trigger, result M cycles after the trigger cycle
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_ready <= 1'b0;
            mul_done  <= 1'b0;
            mul_y     <= '0;
            pend      <= 1'b0;
            cnt       <= 0;
            res_q     <= '0;
        end else begin
            mul_ready <= rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            mul_done  <= 1'b0;
            if (stray_req) begin
                mul_done <= 1'b1;
                mul_y    <= 32'h0001_2345;
            end else if (pend) begin
                if (cnt <= 1) begin
                    pend <= 1'b0;
                    if (!dead) begin
                        mul_done <= 1'b1;
                        mul_y    <= res_q;
                    end
                end else begin
                    cnt <= cnt - 1;
                end
            end else if (mul_trigger) begin
                if (m_lat == 1) begin
                    if (!dead) mul_done <= 1'b1;
                    mul_y <= fx(mul_a, mul_b);
                end else begin
                    pend  <= 1'b1;
                    cnt   <= m_lat - 1;
                    res_q <= fx(mul_a, mul_b);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame; returns in the cycle mix_valid is seen (lat = 0 if it never is).
    task automatic run_frame(input logic [NV*CW-1:0] s, input logic [NV*CW-1:0] g, input logic [NV-1:0] e,
                             input int ovr_at, input int stray_at,
                             output int lat, output int trigs, output int ovrs);
        samples = s; gains = g; voice_en = e; frame_start = 1'b1;
        lat = 0; trigs = 0; ovrs = 0;
        @(posedge clk); #1;
        frame_start = 1'b0;
        for (int k = 1; k <= 200 && lat == 0; k++) begin
            if (mul_trigger) trigs++;
            if (overrun) ovrs++;
            if (mix_valid) begin
                lat = k;
            end else begin
                frame_start = (k == ovr_at);
                stray_req   = (k == stray_at);
                if (k == 2) begin
                    samples  = {$urandom, $urandom, $urandom, $urandom};
                    gains    = {$urandom, $urandom, $urandom, $urandom};
                    voice_en = NV'($urandom);
                end
                @(posedge clk); #1;
                frame_start = 1'b0;
                stray_req   = 1'b0;
            end
        end
    endtask

    function automatic int lat_ref(input logic [NV-1:0] e, input int m);
        int l;
        l = 2;
        for (int v = 0; v < NV; v++) l += e[v] ? (m + 1) : 1;
        return l;
    endfunction

    initial begin
        int lat, trigs, ovrs, err_cyc, errs, valids;
        logic [NV*CW-1:0] s, g;
        logic [NV-1:0]    e;
        logic [CW-1:0]    prev;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mix_out", mix_out, 0);
        check("rst_mix_valid", mix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_trigger", mul_trigger, 0);
        check("rst_flags", {overrun, mul_error}, 0);
        check("rst_mul_a", mul_a, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        m_lat = 3;
        s = {4{32'h200}}; g = {4{32'h100}};
        run_frame(s, g, 4'hF, 0, 0, lat, trigs, ovrs);
        check("t1_mix", mix_out, 32'h800);
        check("t1_lat", lat, NV * (m_lat + 1) + 2);
        check("t1_trigs", trigs, 4);
        @(posedge clk); #1;
        check("t1_valid_pulse", mix_valid, 0);

        s = {4{32'hFFFF_FF00}};
        run_frame(s, g, 4'hF, 0, 0, lat, trigs, ovrs);
        check("t2_sat", mix_out, 32'hFFFF_FFFF);

        run_frame(s, g, 4'h0, 0, 2, lat, trigs, ovrs);
        check("t3_mix", mix_out, 0);
        check("t3_trigs", trigs, 0);
        check("t3_lat", lat, NV + 2);

        s = {32'h0, 32'h300, 32'h0, 32'h100};
        run_frame(s, g, 4'b0101, 0, 0, lat, trigs, ovrs);
        check("t4_mix", mix_out, 32'h400);
        check("t4_trigs", trigs, 2);
        check("t4_lat", lat, lat_ref(4'b0101, m_lat));

        s = {32'h11, 32'h22, 32'h33, 32'h44};
        run_frame(s, g, 4'hF, 3, 0, lat, trigs, ovrs);
        check("t6_ovr_mix", mix_out, mix_ref(s, g, 4'hF));
        check("t6_ovr_cnt", ovrs, 1);
        check("t6_ovr_lat", lat, NV * (m_lat + 1) + 2);
        run_frame(s, g, 4'hF, NV * (m_lat + 1) + 1, 0, lat, trigs, ovrs);
        check("t6_ovr_out_cnt", ovrs, 1);
        check("t6_ovr_out_lat", lat, NV * (m_lat + 1) + 2);

        prev = mix_out;
        dead = 1'b1;
        samples = {4{32'h123}}; voice_en = 4'hF; frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        err_cyc = 0; errs = 0; valids = 0;
        for (int k = 1; k <= 40; k++) begin
            if (mul_error) begin
                errs++;
                if (err_cyc == 0) err_cyc = k;
            end
            if (mix_valid) valids++;
            @(posedge clk); #1;
        end
        check("t5_err_cycle", err_cyc, TO + 2);
        check("t5_err_pulses", errs, 1);
        check("t5_no_valid", valids, 0);
        check("t5_busy", busy, 0);
        check("t5_mix_held", mix_out, prev);
        dead = 1'b0;

        m_lat = 6;
        samples = {4{32'h500}}; voice_en = 4'hF; frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_outs", {mix_out, mix_valid, busy, overrun, mul_error, mul_trigger}, 0);
        check("t6_rst_mul", {mul_a, mul_b}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        s = {32'h400, 32'h300, 32'h200, 32'h100}; g = {32'h80, 32'h100, 32'h200, 32'h100};
        run_frame(s, g, 4'hF, 0, 0, lat, trigs, ovrs);
        check("t6_after_rst_mix", mix_out, mix_ref(s, g, 4'hF));
        check("t6_after_rst_lat", lat, NV * (m_lat + 1) + 2);

        for (int i = 0; i < 10; i++) begin
            m_lat      = $urandom_range(1, 4);
            rand_ready = (i >= 6);
            for (int v = 0; v < NV; v++) begin
                s[v*CW +: CW] = (i % 3 == 0) ? $urandom : CW'($urandom_range(0, 32'hFFFFF));
                g[v*CW +: CW] = CW'($urandom_range(0, 32'h400));
            end
            e = NV'($urandom);
            run_frame(s, g, e, 0, 0, lat, trigs, ovrs);
            check($sformatf("rnd%0d_mix", i), mix_out, mix_ref(s, g, e));
            check($sformatf("rnd%0d_trigs", i), trigs, $countones(e));
            if (!rand_ready) check($sformatf("rnd%0d_lat", i), lat, lat_ref(e, m_lat));
            else check($sformatf("rnd%0d_done", i), lat != 0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
